// File: rtl/audio_sample_sequencer.sv
// audio_sample_sequencer: unpacks a captured word into lane samples and plays them out at a programmable sample period
module audio_sample_sequencer #(
  parameter int WORD_WIDTH   = 32,
  parameter int LANES        = 2,
  parameter int SAMPLE_WIDTH = 8,
  parameter int DIV_WIDTH    = 32
) (
  input  logic                    CLK_50M,
  input  logic                    reset,
  input  logic                    word_valid,
  input  logic [WORD_WIDTH-1:0]   readdata,
  input  logic [DIV_WIDTH-1:0]    sample_clock_divider,
  input  logic                    reverse,
  input  logic                    pause,
  input  logic                    mute,
  output logic                    word_ready,
  output logic [SAMPLE_WIDTH-1:0] out_data,
  output logic                    sample_strobe,
  output logic                    word_done
);
  localparam int SLOT = WORD_WIDTH / LANES;
  localparam int LW   = LANES > 1 ? $clog2(LANES) : 1;
  typedef enum logic [1:0] {IDLE, EMIT, HOLD} state_e;
  state_e                  state_q, state_d;
  logic [WORD_WIDTH-1:0]   word_q, word_d;
  logic                    rev_q, rev_d;
  logic [DIV_WIDTH-1:0]    div_q, div_d, cnt_q, cnt_d, half;
  logic [LW-1:0]           lane_q, lane_d;
  logic [SAMPLE_WIDTH-1:0] data_q, data_d;
  logic                    strobe_q, strobe_d, done_q, done_d;
  logic [SAMPLE_WIDTH-1:0] lane_s [LANES];
  logic                    last, hold_end;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_s[i] = word_q[(i+1)*SLOT-1 -: SAMPLE_WIDTH];
  end
  assign half = sample_clock_divider >> 1;
  assign last = rev_q ? (lane_q == '0) : (lane_q == LW'(LANES - 1));
  // a non-last lane hands over one cycle early so its EMIT lands exactly DIV after the strobe;
  // the last lane counts the full DIV so word_done sits DIV after the final strobe
  assign hold_end = cnt_q == (last ? div_q : div_q - DIV_WIDTH'(1));
  assign word_ready    = state_q == IDLE;
  assign out_data      = data_q;
  assign sample_strobe = strobe_q;
  assign word_done     = done_q;
  // next-state: capture in IDLE, emit one lane per period, pause freezes everything outside IDLE
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    rev_d    = rev_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    lane_d   = lane_q;
    data_d   = data_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      if (word_valid) begin
        word_d  = readdata;
        rev_d   = reverse;
        div_d   = half < DIV_WIDTH'(2) ? DIV_WIDTH'(2) : half;
        lane_d  = reverse ? LW'(LANES - 1) : '0;
        state_d = EMIT;
      end
    end else if (!pause) begin
      if (state_q == EMIT) begin
        data_d   = mute ? '0 : lane_s[lane_q];
        strobe_d = 1'b1;
        cnt_d    = DIV_WIDTH'(1);
        state_d  = HOLD;
      end else if (hold_end) begin
        done_d  = last;
        state_d = last ? IDLE : EMIT;
        lane_d  = last ? lane_q : (rev_q ? lane_q - LW'(1) : lane_q + LW'(1));
      end else begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
      end
    end
  end
  // state register with asynchronous clear
  always_ff @(posedge CLK_50M or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      word_q   <= '0;
      rev_q    <= 1'b0;
      div_q    <= '0;
      cnt_q    <= '0;
      lane_q   <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      rev_q    <= rev_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      lane_q   <= lane_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end
endmodule
